// File: rtl/nes_joypad_pkg.sv
// Shared constants and helpers for the NES controller port: button bit
// positions, default disconnect timeout and the opposing-direction mask.
package nes_joypad_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // 100 ms at 27 MHz
    localparam int STALE_CYCLES_DEFAULT = 2700000;

    // Drops physically impossible Up+Down / Left+Right pairs, which confuse many games.
    function automatic logic [7:0] mask_opposing(input logic [7:0] state, input logic allow);
        logic [7:0] res;
        res = state;
        if (!allow && state[BTN_UP] && state[BTN_DOWN]) begin
            res[BTN_UP]   = 1'b0;
            res[BTN_DOWN] = 1'b0;
        end else begin
            res = res;
        end
        if (!allow && state[BTN_LEFT] && state[BTN_RIGHT]) begin
            res[BTN_LEFT]  = 1'b0;
            res[BTN_RIGHT] = 1'b0;
        end else begin
            res = res;
        end
        return res;
    endfunction

endpackage

// File: rtl/nes_joypad_channel.sv
// One controller channel: valid edge capture with direction masking, disconnect
// timeout, button snapshot and the 4021-style serial shift register.
module nes_joypad_channel
    import nes_joypad_pkg::*;
#(
    parameter int STALE_CYCLES   = STALE_CYCLES_DEFAULT,
    parameter int ALLOW_OPPOSING = 0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] state_i,
    input  logic       valid_i,
    input  logic       reload_i,
    input  logic       shift_i,
    output logic       serial_o,
    output logic       present_o
);

    localparam int                 CNT_W     = $clog2(STALE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   STALE_MAX = CNT_W'(STALE_CYCLES);

    logic             valid_prev_q, valid_prev_d;
    logic [CNT_W-1:0] stale_cnt_q, stale_cnt_d;
    logic [7:0]       snap_q, snap_d;
    logic [7:0]       shift_q, shift_d;
    logic             rise_s;
    logic             stale_s;

    // Next-state logic for edge history, timeout counter, snapshot and shifter.
    always_comb begin
        rise_s       = valid_i & ~valid_prev_q;
        stale_s      = (stale_cnt_q == STALE_MAX);
        valid_prev_d = valid_i;

        if (rise_s) begin
            stale_cnt_d = {CNT_W{1'b0}};
        end else if (stale_s) begin
            stale_cnt_d = stale_cnt_q;
        end else begin
            stale_cnt_d = stale_cnt_q + CNT_W'(1);
        end

        if (rise_s) begin
            snap_d = mask_opposing(state_i, ALLOW_OPPOSING != 0);
        end else if (stale_s) begin
            snap_d = 8'h00;
        end else begin
            snap_d = snap_q;
        end

        // Reload reads the pre-capture snapshot, so a new capture lands one cycle later.
        if (reload_i) begin
            shift_d = snap_q;
        end else if (shift_i) begin
            shift_d = {1'b1, shift_q[7:1]};
        end else begin
            shift_d = shift_q;
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_prev_q <= 1'b0;
            stale_cnt_q  <= {CNT_W{1'b0}};
            snap_q       <= 8'h00;
            shift_q      <= 8'hFF;
        end else begin
            valid_prev_q <= valid_prev_d;
            stale_cnt_q  <= stale_cnt_d;
            snap_q       <= snap_d;
            shift_q      <= shift_d;
        end
    end

    assign serial_o  = shift_q[0];
    assign present_o = ~stale_s;

endmodule

// File: rtl/nes_joypad_port.sv
// CPU-facing $4016/$4017 controller port: strobe latch, per-port shift control
// and the read-data mux with open-bus upper bits.
module nes_joypad_port
    import nes_joypad_pkg::*;
#(
    parameter int STALE_CYCLES   = STALE_CYCLES_DEFAULT,
    parameter int ALLOW_OPPOSING = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_pad1_state,
    input  logic       i_pad1_valid,
    input  logic [7:0] i_pad2_state,
    input  logic       i_pad2_valid,
    input  logic       i_wr,
    input  logic       i_wr_data,
    input  logic       i_rd,
    input  logic       i_rd_port,
    input  logic [7:0] i_open_bus,
    output logic [7:0] o_rd_data,
    output logic [1:0] o_pad_present
);

    logic strobe_q, strobe_d;
    logic shift1_s, shift2_s;
    logic serial1_s, serial2_s;
    logic rd_bit_s;
    logic open_bus_unused_s;

    // Strobe latch follows CPU writes; reads in the same cycle see the old value.
    always_comb begin
        if (i_wr) begin
            strobe_d = i_wr_data;
        end else begin
            strobe_d = strobe_q;
        end
        shift1_s = i_rd & ~i_rd_port & ~strobe_q;
        shift2_s = i_rd &  i_rd_port & ~strobe_q;
        if (i_rd_port) begin
            rd_bit_s = serial2_s;
        end else begin
            rd_bit_s = serial1_s;
        end
    end

    // Strobe register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    nes_joypad_channel #(
        .STALE_CYCLES   (STALE_CYCLES),
        .ALLOW_OPPOSING (ALLOW_OPPOSING)
    ) u_pad1 (
        .clk_i     (i_clk),
        .rst_n_i   (i_rst),
        .state_i   (i_pad1_state),
        .valid_i   (i_pad1_valid),
        .reload_i  (strobe_q),
        .shift_i   (shift1_s),
        .serial_o  (serial1_s),
        .present_o (o_pad_present[0])
    );

    nes_joypad_channel #(
        .STALE_CYCLES   (STALE_CYCLES),
        .ALLOW_OPPOSING (ALLOW_OPPOSING)
    ) u_pad2 (
        .clk_i     (i_clk),
        .rst_n_i   (i_rst),
        .state_i   (i_pad2_state),
        .valid_i   (i_pad2_valid),
        .reload_i  (strobe_q),
        .shift_i   (shift2_s),
        .serial_o  (serial2_s),
        .present_o (o_pad_present[1])
    );

    // Low open-bus bits are replaced by zeros and the serial bit.
    assign open_bus_unused_s = ^i_open_bus[4:0];
    assign o_rd_data         = {i_open_bus[7:5], 4'b0000, rd_bit_s};

endmodule
